// File: rtl/ecg_enc_pkg.sv
// Shared constants and event-word packing for the ECG spike event path.
package ecg_enc_pkg;

    localparam int MASK_POS = 0;
    localparam int MASK_NEG = 1;
    localparam logic [1:0] MARK_WRAP = 2'b00;

    // Event word: {mask[1:0], delta[TS_W-1:0]}; mask sits at offset TS_W.
    localparam int EV_DELTA_LSB = 0;
    localparam int EV_MASK_W = 2;
    localparam int TS_MAX_W = 32;
    localparam int EV_MAX_W = TS_MAX_W + EV_MASK_W;

    function automatic logic [EV_MAX_W-1:0] ev_pack(
        input logic [1:0] mask,
        input logic [TS_MAX_W-1:0] delta,
        input int unsigned ts_w
    );
        logic [EV_MAX_W-1:0] w_m;
        w_m = EV_MAX_W'(mask) << ts_w;
        return w_m | (EV_MAX_W'(delta) << EV_DELTA_LSB);
    endfunction

endpackage

// File: rtl/spike_evt_fifo.sv
// First-word-fall-through event FIFO; a push into a full FIFO
// is accepted only when a pop frees the slot in the same cycle.
module spike_evt_fifo #(
    parameter int WIDTH = 18,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wp;
    logic [AW-1:0]    r_rp;
    logic [LW-1:0]    r_level;
    logic             w_rd;
    logic             w_wr;

    assign empty = (r_level == '0);
    assign full  = (r_level == LW'(DEPTH));
    assign level = r_level;
    assign dout  = r_mem[r_rp];
    assign w_rd  = pop & ~empty;
    assign w_wr  = push & (~full | w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wp] <= din;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wp    <= '0;
            r_rp    <= '0;
            r_level <= '0;
        end else begin
            if (w_wr) r_wp <= r_wp + AW'(1);
            if (w_rd) r_rp <= r_rp + AW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/spike_event_packer.sv
// Packs rising edges of the pos/neg ECG spike neurons into delta-timestamped
// events, inserting wrap markers when the delta counter tops out.
module spike_event_packer
    import ecg_enc_pkg::*;
#(
    parameter int TS_W  = 16,
    parameter int DEPTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   spike_pos,
    input  logic                   spike_neg,
    input  logic                   clr_status,
    output logic [TS_W+1:0]        ev_data,
    output logic                   ev_valid,
    input  logic                   ev_ready,
    output logic [$clog2(DEPTH):0] fifo_level,
    output logic                   overflow,
    output logic [CNT_W-1:0]       drop_cnt
);
    localparam int EV_W = TS_W + 2;

    logic             r_pos_q;
    logic             r_neg_q;
    logic [TS_W-1:0]  r_ts_cnt;
    logic             r_ovf;
    logic [CNT_W-1:0] r_drop;

    logic             w_rise_pos;
    logic             w_rise_neg;
    logic             w_ev;
    logic             w_wrap;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    logic             w_full;
    logic             w_drop;
    logic [1:0]       w_mask;
    logic [EV_W-1:0]  w_word;

    assign w_rise_pos = spike_pos & ~r_pos_q;
    assign w_rise_neg = spike_neg & ~r_neg_q;
    assign w_ev       = en & (w_rise_pos | w_rise_neg);
    assign w_wrap     = en & ~w_ev & (&r_ts_cnt);
    assign w_push     = w_ev | w_wrap;
    assign w_pop      = ev_valid & ev_ready;
    assign w_drop     = w_push & w_full & ~w_pop;

    always_comb begin
        w_mask = MARK_WRAP;
        if (w_ev) begin
            w_mask[MASK_POS] = w_rise_pos;
            w_mask[MASK_NEG] = w_rise_neg;
        end
    end

    assign w_word = EV_W'(ev_pack(w_mask, TS_MAX_W'(r_ts_cnt), TS_W));

    spike_evt_fifo #(
        .WIDTH (EV_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (w_word),
        .pop   (w_pop),
        .dout  (ev_data),
        .empty (w_empty),
        .full  (w_full),
        .level (fifo_level)
    );

    assign ev_valid = ~w_empty;
    assign overflow = r_ovf;
    assign drop_cnt = r_drop;

    // Edge registers track the level every cycle so re-enabling never fires.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_pos_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            r_ts_cnt <= '0;
        end else begin
            r_pos_q <= spike_pos;
            r_neg_q <= spike_neg;
            if (en) begin
                if (w_push) r_ts_cnt <= TS_W'(1);
                else        r_ts_cnt <= r_ts_cnt + TS_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
            if (clr_status)  r_drop <= CNT_W'(1);
            else if (~&r_drop) r_drop <= r_drop + CNT_W'(1);
        end else if (clr_status) begin
            r_ovf  <= 1'b0;
            r_drop <= '0;
        end
    end

endmodule
